// File: rtl/dm_access_pkg.sv
// Shared types for the data-memory access controller: size codes, FSM states
// and the width of the latency counter used for the read and write phases.
package dm_access_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_X = 2'd3
  } size_t;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR,
    GAP,
    RESP
  } state_t;

  // Wide enough for RD_LAT and WR_HOLD + 1 up to 255.
  localparam int CNT_W = 8;

endpackage

// File: rtl/dm_access_ctrl_if.sv
// Bus bundles for the access controller: the pipeline-facing request/response
// channel and the word-addressed data-memory port.
interface dm_req_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_err;
  logic [31:0] rsp_rdata;

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_err, rsp_rdata
  );
endinterface

interface dm_mem_if #(parameter int ADDR_W = 5);
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_write;
  logic              mem_read;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_addr, mem_wdata, mem_write, mem_read,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_write, mem_read,
    output mem_rdata
  );
endinterface

// File: rtl/dm_lane_align.sv
// Byte/half lane handling: extracts and extends load data from a memory word,
// and builds the merged word for sub-word stores.
module dm_lane_align
  import dm_access_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  size_t       size,
  input  logic        sign_ext,
  input  logic [15:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0]  byte_val;
  logic [15:0] half_val;

  // Select the addressed lane, extend it for loads and splice store data into it.
  always_comb begin
    byte_val  = word[{lane, 3'b000} +: 8];
    half_val  = lane[1] ? word[31:16] : word[15:0];
    load_data = word;
    merged    = word;
    case (size)
      SZ_B: begin
        load_data = {{24{sign_ext & byte_val[7]}}, byte_val};
        merged[{lane, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_H: begin
        load_data = {{16{sign_ext & half_val[15]}}, half_val};
        if (lane[1]) merged[31:16] = wdata;
        else         merged[15:0]  = wdata;
      end
      default: begin
        load_data = word;
        merged    = word;
      end
    endcase
  end

endmodule

// File: rtl/dm_access_ctrl.sv
// Initiator side of the data-memory interface. Turns one load/store request at
// a time into memory strobes, using read-modify-write for sub-word stores, and
// returns the load result or an error status.
module dm_access_ctrl
  import dm_access_pkg::*;
#(
  parameter int ADDR_W  = 5,
  parameter int RD_LAT  = 1,
  parameter int WR_HOLD = 1
) (
  input  logic     clk,
  input  logic     reset_n,
  dm_req_if.slave  req,
  dm_mem_if.master mem
);

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic              after_rd;
  logic              wr_q, signed_q;
  size_t             size_q;
  logic [1:0]        lane_q;
  logic [15:0]       wdata_q;
  logic [31:0]       rdata_q;

  logic              accept, req_err;
  size_t             req_size;
  logic              mem_read_nx, mem_write_nx;
  logic [31:0]       align_word, load_data, merged;

  assign req_size = size_t'(req.req_size);
  assign accept   = req.req_valid & req.req_ready;

  // Reject illegal sizes, misaligned accesses and addresses beyond the memory.
  always_comb begin
    req_err = (req_size == SZ_X)
            | ((req_size == SZ_H) & req.req_addr[0])
            | ((req_size == SZ_W) & (req.req_addr[1:0] != 2'b00))
            | (|req.req_addr[31:ADDR_W+2]);
  end

  // State register and latency counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      after_rd <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      after_rd <= (state == RD);
    end
  end

  // Next state, counter reload and next strobe values; a word store spends its
  // first WR cycle with the strobe low so mem_wdata is set up ahead of it.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_err) begin
            state_nx = RESP;
          end else if (req.req_write && (req_size == SZ_W)) begin
            state_nx = WR;
            cnt_nx   = CNT_W'(WR_HOLD);
          end else begin
            state_nx = RD;
            cnt_nx   = CNT_W'(RD_LAT - 1);
          end
        end
      end
      RD, WR: begin
        if (cnt == '0) state_nx = GAP;
        else           cnt_nx   = cnt - 1'b1;
      end
      GAP: begin
        if (after_rd && wr_q) begin
          state_nx = WR;
          cnt_nx   = CNT_W'(WR_HOLD - 1);
        end else begin
          state_nx = RESP;
        end
      end
      RESP: begin
        if (req.rsp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    mem_read_nx  = (state_nx == RD);
    mem_write_nx = (state_nx == WR) && (state != IDLE);
  end

  assign align_word = (state == RD) ? mem.mem_rdata : rdata_q;

  dm_lane_align u_align (
    .word      (align_word),
    .lane      (lane_q),
    .size      (size_q),
    .sign_ext  (signed_q),
    .wdata     (wdata_q),
    .load_data (load_data),
    .merged    (merged)
  );

  // Registered outputs, request latch, read capture and response register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req.req_ready <= 1'b0;
      req.rsp_valid <= 1'b0;
      req.rsp_err   <= 1'b0;
      req.rsp_rdata <= '0;
      mem.mem_read  <= 1'b0;
      mem.mem_write <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
      wr_q          <= 1'b0;
      signed_q      <= 1'b0;
      size_q        <= SZ_B;
      lane_q        <= '0;
      wdata_q       <= '0;
      rdata_q       <= '0;
    end else begin
      req.req_ready <= (state_nx == IDLE);
      req.rsp_valid <= (state_nx == RESP);
      mem.mem_read  <= mem_read_nx;
      mem.mem_write <= mem_write_nx;
      if (state == IDLE && accept) begin
        wr_q     <= req.req_write;
        signed_q <= req.req_signed;
        size_q   <= req_size;
        lane_q   <= req.req_addr[1:0];
        wdata_q  <= req.req_wdata[15:0];
        if (!req_err) begin
          mem.mem_addr <= req.req_addr[ADDR_W+1:2];
          if (req.req_write && (req_size == SZ_W)) mem.mem_wdata <= req.req_wdata;
        end
      end
      if (state == RD && cnt == '0) begin
        rdata_q       <= mem.mem_rdata;
        mem.mem_wdata <= merged;
      end
      if (state != RESP && state_nx == RESP) begin
        req.rsp_err   <= (state == IDLE);
        req.rsp_rdata <= (state == GAP && !wr_q) ? load_data : 32'h0;
      end else if (state == RESP && state_nx == IDLE) begin
        req.rsp_err   <= 1'b0;
        req.rsp_rdata <= '0;
      end
    end
  end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Directed bench for dm_access_ctrl with a behavioural word memory.
module tb_dm_access_ctrl;
  import dm_access_pkg::*;

  localparam int ADDR_W = 5;
  localparam int NVEC   = 24;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_rd;
    int          exp_wr;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   total = 0;
  int   passed = 0;
  int   rd_cycles = 0;
  int   wr_cycles = 0;
  int   overlap_errs = 0;
  vec_t vecs [NVEC];
  logic [31:0] mem_array [0:31] = '{default: 32'h0};

  dm_req_if req_bus ();
  dm_mem_if #(.ADDR_W(ADDR_W)) mem_bus ();

  dm_access_ctrl #(.ADDR_W(ADDR_W), .RD_LAT(1), .WR_HOLD(1)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req_bus),
    .mem     (mem_bus)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Behavioural memory: asynchronous read, write on the rising edge.
  always @(posedge clk) begin
    if (mem_bus.mem_write) mem_array[mem_bus.mem_addr] <= mem_bus.mem_wdata;
  end
  assign mem_bus.mem_rdata = mem_array[mem_bus.mem_addr];

  // Strobe activity counters and the read/write exclusivity check.
  always @(negedge clk) begin
    if (mem_bus.mem_read)  rd_cycles++;
    if (mem_bus.mem_write) wr_cycles++;
    assert (!(mem_bus.mem_read && mem_bus.mem_write))
      else begin
        overlap_errs++;
        $display("[TB] FAIL strobe_overlap: got read=1 write=1 expected not both");
      end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual === expected) passed++;
    else $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
  endtask

  task automatic reportTimeout(input string name);
    total++;
    $display("[TB] FAIL %s: got timeout expected handshake", name);
  endtask

  task automatic applyStimulus(input vec_t v, output logic got_err, output logic [31:0] got_rdata,
                               output int got_rd, output int got_wr, output bit ok);
    int n;
    int rd0;
    int wr0;
    rd0 = rd_cycles;
    wr0 = wr_cycles;
    ok = 1'b0;
    got_err = 1'bx;
    got_rdata = 'x;
    got_rd = 0;
    got_wr = 0;
    @(negedge clk);
    req_bus.req_write  = v.wr;
    req_bus.req_size   = v.size;
    req_bus.req_signed = v.sgn;
    req_bus.req_addr   = v.addr;
    req_bus.req_wdata  = v.wdata;
    req_bus.req_valid  = 1'b1;
    n = 0;
    while (!req_bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_bus.req_ready) begin
      req_bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 req_bus.req_valid = 1'b0;
    @(negedge clk);
    n = 0;
    while (!req_bus.rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_bus.rsp_valid) return;
    got_err   = req_bus.rsp_err;
    got_rdata = req_bus.rsp_rdata;
    @(posedge clk);
    #1;
    got_rd = rd_cycles - rd0;
    got_wr = wr_cycles - wr0;
    ok = 1'b1;
  endtask

  initial begin
    logic        g_err;
    logic [31:0] g_rdata;
    int          g_rd;
    int          g_wr;
    bit          ok;
    int          n;
    int          wr0;
    logic        saw_rsp;

    vecs[0]  = '{1'b1, 2'd2, 1'b0, 32'h0000_000C, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000, 0, 1};
    vecs[1]  = '{1'b0, 2'd2, 1'b0, 32'h0000_000C, 32'h0,         1'b0, 32'hDEAD_BEEF, 1, 0};
    vecs[2]  = '{1'b1, 2'd2, 1'b0, 32'h0000_0010, 32'h1122_3344, 1'b0, 32'h0000_0000, 0, 1};
    vecs[3]  = '{1'b0, 2'd0, 1'b1, 32'h0000_0013, 32'h0,         1'b0, 32'h0000_0011, 1, 0};
    vecs[4]  = '{1'b1, 2'd0, 1'b0, 32'h0000_0011, 32'h0000_0080, 1'b0, 32'h0000_0000, 1, 1};
    vecs[5]  = '{1'b0, 2'd0, 1'b1, 32'h0000_0011, 32'h0,         1'b0, 32'hFFFF_FF80, 1, 0};
    vecs[6]  = '{1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'h1122_8044, 1, 0};
    vecs[7]  = '{1'b1, 2'd2, 1'b0, 32'h0000_0010, 32'h8001_0000, 1'b0, 32'h0000_0000, 0, 1};
    vecs[8]  = '{1'b0, 2'd1, 1'b1, 32'h0000_0012, 32'h0,         1'b0, 32'hFFFF_8001, 1, 0};
    vecs[9]  = '{1'b0, 2'd1, 1'b0, 32'h0000_0012, 32'h0,         1'b0, 32'h0000_8001, 1, 0};
    vecs[10] = '{1'b0, 2'd1, 1'b1, 32'h0000_0010, 32'h0,         1'b0, 32'h0000_0000, 1, 0};
    vecs[11] = '{1'b1, 2'd1, 1'b0, 32'h0000_0012, 32'h1234_ABCD, 1'b0, 32'h0000_0000, 1, 1};
    vecs[12] = '{1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hABCD_0000, 1, 0};
    vecs[13] = '{1'b0, 2'd0, 1'b1, 32'h0000_0012, 32'h0,         1'b0, 32'hFFFF_FFCD, 1, 0};
    vecs[14] = '{1'b0, 2'd0, 1'b0, 32'h0000_0013, 32'h0,         1'b0, 32'h0000_00AB, 1, 0};
    vecs[15] = '{1'b0, 2'd1, 1'b0, 32'h0000_0005, 32'h0,         1'b1, 32'h0000_0000, 0, 0};
    vecs[16] = '{1'b0, 2'd2, 1'b0, 32'h0000_0006, 32'h0,         1'b1, 32'h0000_0000, 0, 0};
    vecs[17] = '{1'b0, 2'd2, 1'b0, 32'h0000_0080, 32'h0,         1'b1, 32'h0000_0000, 0, 0};
    vecs[18] = '{1'b0, 2'd3, 1'b0, 32'h0000_0000, 32'h0,         1'b1, 32'h0000_0000, 0, 0};
    vecs[19] = '{1'b1, 2'd2, 1'b0, 32'h0000_0084, 32'hCAFE_F00D, 1'b1, 32'h0000_0000, 0, 0};
    vecs[20] = '{1'b1, 2'd0, 1'b0, 32'h0000_007D, 32'h0000_005A, 1'b0, 32'h0000_0000, 1, 1};
    vecs[21] = '{1'b0, 2'd2, 1'b0, 32'h0000_007C, 32'h0,         1'b0, 32'h0000_5A00, 1, 0};
    vecs[22] = '{1'b0, 2'd2, 1'b1, 32'h0000_000C, 32'h0,         1'b0, 32'hDEAD_BEEF, 1, 0};
    vecs[23] = '{1'b0, 2'd0, 1'b1, 32'h0000_007D, 32'h0,         1'b0, 32'h0000_005A, 1, 0};

    req_bus.req_valid  = 1'b0;
    req_bus.req_write  = 1'b0;
    req_bus.req_size   = 2'd0;
    req_bus.req_signed = 1'b0;
    req_bus.req_addr   = 32'h0;
    req_bus.req_wdata  = 32'h0;
    req_bus.rsp_ready  = 1'b1;

    repeat (2) @(negedge clk);
    checkOutput("reset_req_ready", {31'b0, req_bus.req_ready}, 32'd0);
    checkOutput("reset_rsp_valid", {31'b0, req_bus.rsp_valid}, 32'd0);
    checkOutput("reset_rsp_err",   {31'b0, req_bus.rsp_err},   32'd0);
    checkOutput("reset_strobes",   {30'b0, mem_bus.mem_read, mem_bus.mem_write}, 32'd0);
    checkOutput("reset_rsp_rdata", req_bus.rsp_rdata, 32'd0);
    checkOutput("reset_mem_addr",  {27'b0, mem_bus.mem_addr}, 32'd0);
    checkOutput("reset_mem_wdata", mem_bus.mem_wdata, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("ready_after_reset", {31'b0, req_bus.req_ready}, 32'd1);

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i], g_err, g_rdata, g_rd, g_wr, ok);
      if (!ok) begin
        reportTimeout($sformatf("vec%0d_timeout", i));
      end else begin
        checkOutput($sformatf("vec%0d_err", i),   {31'b0, g_err}, {31'b0, vecs[i].exp_err});
        checkOutput($sformatf("vec%0d_rdata", i), g_rdata, vecs[i].exp_rdata);
        checkOutput($sformatf("vec%0d_rd_cycles", i), g_rd, vecs[i].exp_rd);
        checkOutput($sformatf("vec%0d_wr_cycles", i), g_wr, vecs[i].exp_wr);
      end
    end

    @(negedge clk);
    req_bus.rsp_ready  = 1'b0;
    req_bus.req_write  = 1'b0;
    req_bus.req_size   = 2'd2;
    req_bus.req_signed = 1'b0;
    req_bus.req_addr   = 32'h0000_000C;
    req_bus.req_valid  = 1'b1;
    @(posedge clk);
    #1 req_bus.req_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!req_bus.rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_bus.rsp_valid) reportTimeout("stall_rsp_timeout");
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput($sformatf("stall%0d_rsp_valid", k), {31'b0, req_bus.rsp_valid}, 32'd1);
      checkOutput($sformatf("stall%0d_rsp_rdata", k), req_bus.rsp_rdata, 32'hDEAD_BEEF);
      checkOutput($sformatf("stall%0d_rsp_err", k),   {31'b0, req_bus.rsp_err}, 32'd0);
      checkOutput($sformatf("stall%0d_req_ready", k), {31'b0, req_bus.req_ready}, 32'd0);
      checkOutput($sformatf("stall%0d_strobes", k),
                  {30'b0, mem_bus.mem_read, mem_bus.mem_write}, 32'd0);
    end
    req_bus.rsp_ready = 1'b1;
    req_bus.req_addr  = 32'h0000_0010;
    req_bus.req_valid = 1'b1;
    @(negedge clk);
    checkOutput("b2b_ready_after_handshake", {31'b0, req_bus.req_ready}, 32'd1);
    checkOutput("b2b_rsp_valid_dropped",     {31'b0, req_bus.rsp_valid}, 32'd0);
    @(posedge clk);
    #1 req_bus.req_valid = 1'b0;
    @(negedge clk);
    checkOutput("b2b_accepted", {31'b0, req_bus.req_ready}, 32'd0);
    n = 0;
    while (!req_bus.rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_bus.rsp_valid) reportTimeout("b2b_rsp_timeout");
    else checkOutput("b2b_rdata", req_bus.rsp_rdata, 32'hABCD_0000);
    @(posedge clk);
    #1;

    wr0 = wr_cycles;
    @(negedge clk);
    req_bus.req_write  = 1'b1;
    req_bus.req_size   = 2'd0;
    req_bus.req_addr   = 32'h0000_007D;
    req_bus.req_wdata  = 32'h0000_00FF;
    req_bus.req_valid  = 1'b1;
    @(posedge clk);
    #1 req_bus.req_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!mem_bus.mem_read && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!mem_bus.mem_read) reportTimeout("rmw_read_timeout");
    #2 reset_n = 1'b0;
    #1;
    checkOutput("rst_mid_strobes", {30'b0, mem_bus.mem_read, mem_bus.mem_write}, 32'd0);
    saw_rsp = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (req_bus.rsp_valid) saw_rsp = 1'b1;
    end
    reset_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (req_bus.rsp_valid) saw_rsp = 1'b1;
    end
    checkOutput("rst_mid_no_rsp",     {31'b0, saw_rsp}, 32'd0);
    checkOutput("rst_mid_no_write",   wr_cycles - wr0, 32'd0);
    checkOutput("rst_mid_mem_intact", mem_array[31], 32'h0000_5A00);
    checkOutput("rst_mid_ready",      {31'b0, req_bus.req_ready}, 32'd1);
    checkOutput("strobe_overlap_total", overlap_errs, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
